// File: rtl/cv32e40p_tmr_voter_monitor.sv
// Per-channel TMR voter with registered output, error flags and saturating corrected-event counter.
// Optional CV32E40P_FT_REPLICA_EXCLUDE_EN adds permanent-fault exclusion (TMR -> DUPLEX -> FAIL).
module cv32e40p_tmr_voter_monitor #(
  parameter int N_CH     = 2,
  parameter int CH_W     = 32,
  parameter int PERM_THR = 8,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_i,
  input  logic [N_CH*CH_W-1:0] in_1_i,
  input  logic [N_CH*CH_W-1:0] in_2_i,
  input  logic [N_CH*CH_W-1:0] in_3_i,
  input  logic                 clear_i,
  output logic [N_CH*CH_W-1:0] voted_o,
  output logic                 voted_valid_o,
  output logic                 err_corrected_o,
  output logic                 err_detected_o,
  output logic                 err_uncorr_o,
  output logic [CNT_W-1:0]     err_cnt_o,
  output logic [2:0]           replica_faulty_o,
  output logic [1:0]           mode_o
);
  localparam int W = N_CH * CH_W;

  if (PERM_THR < 2 || PERM_THR > 255) begin : g_thr_chk
    $error("PERM_THR must be in 2..255");
  end

  logic [N_CH-1:0] w_eq12, w_eq13, w_eq23, w_cor, w_unc;
  logic [W-1:0]    w_tmr;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [CH_W-1:0] w_a, w_b, w_c;
    assign w_a = in_1_i[c*CH_W +: CH_W];
    assign w_b = in_2_i[c*CH_W +: CH_W];
    assign w_c = in_3_i[c*CH_W +: CH_W];
    assign w_eq12[c] = (w_a == w_b);
    assign w_eq13[c] = (w_a == w_c);
    assign w_eq23[c] = (w_b == w_c);
    // bitwise majority also equals the agreeing value when exactly two replicas match
    assign w_tmr[c*CH_W +: CH_W] = (w_a & w_b) | (w_a & w_c) | (w_b & w_c);
    assign w_cor[c] = (w_eq12[c] | w_eq13[c] | w_eq23[c]) & ~(w_eq12[c] & w_eq23[c]);
    assign w_unc[c] = ~(w_eq12[c] | w_eq13[c] | w_eq23[c]);
  end

  logic [W-1:0] w_out;
  logic         w_cor_any, w_det_any, w_unc_any;

`ifdef CV32E40P_FT_REPLICA_EXCLUDE_EN
  typedef enum logic [1:0] {M_TMR = 2'b00, M_DUPLEX = 2'b01, M_FAIL = 2'b10} mode_e;
  localparam logic [7:0] THR = 8'(PERM_THR);

  mode_e           r_mode, w_mode_nxt;
  logic [2:0][7:0] r_cul_cnt, w_cul_cnt_nxt;
  logic [7:0]      r_mis_cnt, w_mis_cnt_nxt;
  logic [2:0]      r_faulty, w_faulty_nxt;
  logic [2:0]      w_cul, w_hit;
  logic [W-1:0]    w_lo, w_hi;
  logic            w_mis;

  always_comb begin
    w_cul = '0;
    for (int c = 0; c < N_CH; c++) begin
      w_cul[0] = w_cul[0] | (w_eq23[c] & ~w_eq12[c]);
      w_cul[1] = w_cul[1] | (w_eq13[c] & ~w_eq12[c]);
      w_cul[2] = w_cul[2] | (w_eq12[c] & ~w_eq13[c]);
    end
    for (int r = 0; r < 3; r++)
      w_hit[r] = w_cul[r] && ((r_cul_cnt[r] + 8'd1) == THR);
  end

  // healthy pair in index order; the excluded replica never feeds DUPLEX/FAIL
  assign w_lo  = r_faulty[0] ? in_2_i : in_1_i;
  assign w_hi  = (r_faulty[0] | r_faulty[1]) ? in_3_i : in_2_i;
  assign w_mis = (w_lo != w_hi);

  always_comb begin
    w_out     = w_tmr;
    w_cor_any = (|w_cor) & ~(|w_unc);
    w_unc_any = |w_unc;
    w_det_any = (|w_cor) | (|w_unc);
    case (r_mode)
      M_DUPLEX: begin
        w_out     = w_lo;
        w_cor_any = 1'b0;
        w_unc_any = w_mis;
        w_det_any = w_mis;
      end
      M_FAIL: begin
        w_out     = w_lo;
        w_cor_any = 1'b0;
        w_unc_any = 1'b1;
        w_det_any = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_mode_nxt    = r_mode;
    w_cul_cnt_nxt = r_cul_cnt;
    w_mis_cnt_nxt = r_mis_cnt;
    w_faulty_nxt  = r_faulty;
    if (clear_i) begin
      w_mode_nxt    = M_TMR;
      w_cul_cnt_nxt = '0;
      w_mis_cnt_nxt = '0;
      w_faulty_nxt  = '0;
    end else if (valid_i) begin
      case (r_mode)
        M_TMR: begin
          for (int r = 0; r < 3; r++)
            w_cul_cnt_nxt[r] = w_cul[r] ? r_cul_cnt[r] + 8'd1 : 8'd0;
          if (|w_hit) begin
            w_faulty_nxt  = w_hit & (~w_hit + 3'd1);
            w_mode_nxt    = M_DUPLEX;
            w_cul_cnt_nxt = '0;
          end
        end
        M_DUPLEX: begin
          w_mis_cnt_nxt = w_mis ? r_mis_cnt + 8'd1 : 8'd0;
          if (w_mis && ((r_mis_cnt + 8'd1) == THR)) begin
            w_mode_nxt    = M_FAIL;
            w_mis_cnt_nxt = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode    <= M_TMR;
      r_cul_cnt <= '0;
      r_mis_cnt <= '0;
      r_faulty  <= '0;
    end else begin
      r_mode    <= w_mode_nxt;
      r_cul_cnt <= w_cul_cnt_nxt;
      r_mis_cnt <= w_mis_cnt_nxt;
      r_faulty  <= w_faulty_nxt;
    end
  end

  assign mode_o           = r_mode;
  assign replica_faulty_o = r_faulty;
`else
  assign w_out            = w_tmr;
  assign w_cor_any        = (|w_cor) & ~(|w_unc);
  assign w_unc_any        = |w_unc;
  assign w_det_any        = (|w_cor) | (|w_unc);
  assign mode_o           = 2'b00;
  assign replica_faulty_o = 3'b000;
`endif

  logic [W-1:0]     r_voted;
  logic             r_vv, r_cor, r_det, r_unc;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_voted <= '0;
      r_vv    <= 1'b0;
      r_cor   <= 1'b0;
      r_det   <= 1'b0;
      r_unc   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_vv  <= valid_i;
      r_cor <= valid_i & w_cor_any;
      r_det <= valid_i & w_det_any;
      r_unc <= valid_i & w_unc_any;
      if (valid_i) r_voted <= w_out;
      if (clear_i)
        r_cnt <= '0;
      else if (valid_i && w_cor_any && (r_cnt != '1))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign voted_o         = r_voted;
  assign voted_valid_o   = r_vv;
  assign err_corrected_o = r_cor;
  assign err_detected_o  = r_det;
  assign err_uncorr_o    = r_unc;
  assign err_cnt_o       = r_cnt;
endmodule

// File: tb/tb_cv32e40p_tmr_voter_monitor.sv
// Scoreboard bench for cv32e40p_tmr_voter_monitor (N_CH=2, CH_W=8, PERM_THR=4, CNT_W=4).
// Expectations follow CV32E40P_FT_REPLICA_EXCLUDE_EN when it is defined for the build.
module tb_cv32e40p_tmr_voter_monitor;
`ifdef CV32E40P_FT_REPLICA_EXCLUDE_EN
  localparam bit EX = 1'b1;
`else
  localparam bit EX = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] voted;
    logic        vv, cor, det, unc;
    logic [3:0]  cnt;
    logic [2:0]  faulty;
    logic [1:0]  mode;
  } exp_t;

  logic        clk = 1'b0, rst_n = 1'b0, valid_i = 1'b0, clear_i = 1'b0;
  logic [15:0] in_1_i = '0, in_2_i = '0, in_3_i = '0;
  logic [15:0] voted_o;
  logic        voted_valid_o, err_corrected_o, err_detected_o, err_uncorr_o;
  logic [3:0]  err_cnt_o;
  logic [2:0]  replica_faulty_o;
  logic [1:0]  mode_o;

  int          total = 0, bad = 0;
  logic [3:0]  exp_cnt = '0;
  logic [2:0]  exp_faulty = '0;
  logic [1:0]  exp_mode = '0;
  exp_t        sb[$];

  always #5 clk = ~clk;

  cv32e40p_tmr_voter_monitor #(.N_CH(2), .CH_W(8), .PERM_THR(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i),
    .in_1_i(in_1_i), .in_2_i(in_2_i), .in_3_i(in_3_i), .clear_i(clear_i),
    .voted_o(voted_o), .voted_valid_o(voted_valid_o),
    .err_corrected_o(err_corrected_o), .err_detected_o(err_detected_o),
    .err_uncorr_o(err_uncorr_o), .err_cnt_o(err_cnt_o),
    .replica_faulty_o(replica_faulty_o), .mode_o(mode_o)
  );

  function automatic exp_t sample();
    return {voted_o, voted_valid_o, err_corrected_o, err_detected_o, err_uncorr_o,
            err_cnt_o, replica_faulty_o, mode_o};
  endfunction

  function automatic exp_t mk(input logic [15:0] v, input logic vv, cor, det, unc);
    return {v, vv, cor, det, unc, exp_cnt, exp_faulty, exp_mode};
  endfunction

  task automatic inc();
    if (exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
  endtask

  task automatic drive(input logic v, input logic [15:0] a, b, c, input logic clr, input exp_t e);
    valid_i = v; in_1_i = a; in_2_i = b; in_3_i = c; clear_i = clr;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; valid_i = 1'b0; clear_i = 1'b0;
    exp_cnt = '0; exp_faulty = '0; exp_mode = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t o;
    rst_n = 1'b0; valid_i = 1'b1; in_1_i = 16'h1357; in_2_i = 16'h2468; in_3_i = 16'h9ABC;
    @(posedge clk); #1;
    o = sample(); total++;
    if (o !== '0) begin bad++; $display("FAIL reset got=%h exp=0", o); end
    valid_i = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_clean();
    exp_t e, o;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) drive(1'b1, 16'hA53C, 16'hA53C, 16'hA53C, 1'b0, mk(16'hA53C, 1'b1, 1'b0, 1'b0, 1'b0));
      else        drive(1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, mk(16'hA53C, 1'b0, 1'b0, 1'b0, 1'b0));
      @(posedge clk); #1;
      e = sb.pop_front(); o = sample(); total++;
      if (o !== e) begin bad++; $display("FAIL clean[%0d] got=%h exp=%h", i, o, e); end
    end
  endtask

  task automatic test_corrected();
    exp_t e, o;
    inc();
    drive(1'b1, 16'h0000, 16'h00FF, 16'h0000, 1'b0, mk(16'h0000, 1'b1, 1'b1, 1'b1, 1'b0));
    @(posedge clk); #1;
    e = sb.pop_front(); o = sample(); total++;
    if (o !== e) begin bad++; $display("FAIL corrected got=%h exp=%h", o, e); end
  endtask

  task automatic test_uncorr();
    exp_t e, o;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) drive(1'b1, 16'h0110, 16'h0210, 16'h0410, 1'b0, mk(16'h0010, 1'b1, 1'b0, 1'b1, 1'b1));
      else        drive(1'b1, 16'h0110, 16'h0211, 16'h0410, 1'b0, mk(16'h0010, 1'b1, 1'b0, 1'b1, 1'b1));
      @(posedge clk); #1;
      e = sb.pop_front(); o = sample(); total++;
      if (o !== e) begin bad++; $display("FAIL uncorr[%0d] got=%h exp=%h", i, o, e); end
    end
  endtask

  task automatic test_duplex();
    exp_t e, o;
    logic v;
    for (int i = 0; i < 8; i++) begin
      if (i < 5) begin
        v = (i != 2);
        if (v) inc();
        if (i == 4 && EX) begin exp_faulty = 3'b100; exp_mode = 2'b01; end
        drive(v, 16'h1234, 16'h1234, 16'h1235, 1'b0, mk(16'h1234, v, v, v, 1'b0));
      end else if (i == 5) begin
        if (!EX) inc();
        drive(1'b1, 16'h5555, 16'h5555, 16'hFFFF, 1'b0, mk(16'h5555, 1'b1, !EX, !EX, 1'b0));
      end else begin
        if (!EX) inc();
        drive(1'b1, 16'h0001, 16'h0002, 16'h0002, 1'b0,
              EX ? mk(16'h0001, 1'b1, 1'b0, 1'b1, 1'b1) : mk(16'h0002, 1'b1, 1'b1, 1'b1, 1'b0));
      end
      @(posedge clk); #1;
      e = sb.pop_front(); o = sample(); total++;
      if (o !== e) begin bad++; $display("FAIL duplex[%0d] got=%h exp=%h", i, o, e); end
    end
  endtask

  task automatic test_clear();
    exp_t e, o;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        exp_cnt = '0; exp_faulty = '0; exp_mode = '0;
        drive(1'b1, 16'h1111, 16'h2222, 16'h1111, 1'b1, mk(16'h1111, 1'b1, !EX, 1'b1, EX));
      end else begin
        inc();
        drive(1'b1, 16'h4444, 16'h4444, 16'h4C44, 1'b0, mk(16'h4444, 1'b1, 1'b1, 1'b1, 1'b0));
      end
      @(posedge clk); #1;
      e = sb.pop_front(); o = sample(); total++;
      if (o !== e) begin bad++; $display("FAIL clear[%0d] got=%h exp=%h", i, o, e); end
    end
    clear_i = 1'b0;
  endtask

  task automatic test_fail();
    exp_t e, o;
    for (int i = 0; i < 10; i++) begin
      if (i < 4) begin
        inc();
        if (i == 3 && EX) begin exp_faulty = 3'b001; exp_mode = 2'b01; end
        drive(1'b1, 16'h9998, 16'h9999, 16'h9999, 1'b0, mk(16'h9999, 1'b1, 1'b1, 1'b1, 1'b0));
      end else if (i < 8) begin
        if (!EX) inc();
        if (i == 7 && EX) exp_mode = 2'b10;
        drive(1'b1, 16'h0A0A, 16'h0A0A, 16'h0B0B, 1'b0, mk(16'h0A0A, 1'b1, !EX, 1'b1, EX));
      end else if (i == 8) begin
        drive(1'b1, 16'h7777, 16'h7777, 16'h7777, 1'b0, mk(16'h7777, 1'b1, 1'b0, EX, EX));
      end else begin
        drive(1'b0, 16'h0000, 16'h1111, 16'h2222, 1'b0, mk(16'h7777, 1'b0, 1'b0, 1'b0, 1'b0));
      end
      @(posedge clk); #1;
      e = sb.pop_front(); o = sample(); total++;
      if (o !== e) begin bad++; $display("FAIL fail_mode[%0d] got=%h exp=%h", i, o, e); end
    end
  endtask

  task automatic test_saturate_reset();
    exp_t e, o;
    logic [15:0] base, a, b, c;
    base = 16'h3C3C;
    do_reset();
    for (int i = 0; i < 23; i++) begin
      a = base; b = base; c = base;
      if (i >= 20 || (i % 3) == 2) c = base ^ 16'h0001;
      else if ((i % 3) == 0)       a = base ^ 16'h0001;
      else                          b = base ^ 16'h0001;
      inc();
      drive(1'b1, a, b, c, 1'b0, mk(base, 1'b1, 1'b1, 1'b1, 1'b0));
      @(posedge clk); #1;
      e = sb.pop_front(); o = sample(); total++;
      if (o !== e) begin bad++; $display("FAIL saturate[%0d] got=%h exp=%h", i, o, e); end
    end
    #2 rst_n = 1'b0;
    #1;
    o = sample(); total++;
    if (o !== '0) begin bad++; $display("FAIL async_reset got=%h exp=0", o); end
    valid_i = 1'b0;
    exp_cnt = '0; exp_faulty = '0; exp_mode = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inc();
      if (i == 3 && EX) begin exp_faulty = 3'b100; exp_mode = 2'b01; end
      drive(1'b1, base, base, base ^ 16'h0100, 1'b0, mk(base, 1'b1, 1'b1, 1'b1, 1'b0));
      @(posedge clk); #1;
      e = sb.pop_front(); o = sample(); total++;
      if (o !== e) begin bad++; $display("FAIL post_reset[%0d] got=%h exp=%h", i, o, e); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_clean();
    test_corrected();
    test_uncorr();
    test_duplex();
    test_clear();
    test_fail();
    test_saturate_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cv32e40p_tmr_voter_monitor.md
CV32E40P_TMR_VOTER_MONITOR -- requirements
Module: cv32e40p_tmr_voter_monitor

Interface
REQ-001 Parameter N_CH, default 2: number of independently voted channels.
REQ-002 Parameter CH_W, default 32: bits per channel; channel c occupies bits [c*CH_W +: CH_W].
REQ-003 Parameter PERM_THR, default 8, range 2..255: consecutive valid culprit cycles that mark a replica permanently faulty.
REQ-004 Parameter CNT_W, default 16: corrected-event counter width.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 valid_i  in  1  replica outputs valid this cycle.
REQ-008 in_1_i, in_2_i, in_3_i  in  N_CH*CH_W  replica outputs.
REQ-009 clear_i  in  1  synchronous clear of counters, sticky flags and mode.
REQ-010 voted_o  out  N_CH*CH_W  registered voted data.
REQ-011 voted_valid_o  out  1  voted_o valid.
REQ-012 err_corrected_o  out  1  at least one channel corrected, none uncorrectable.
REQ-013 err_detected_o  out  1  any channel disagreed (corrected or not).
REQ-014 err_uncorr_o  out  1  at least one channel uncorrectable.
REQ-015 err_cnt_o  out  CNT_W  saturating count of valid cycles with err_corrected.
REQ-016 replica_faulty_o  out  3  sticky per-replica permanent-fault flags (bit0 = in_1_i).
REQ-017 mode_o  out  2  00 TMR, 01 DUPLEX, 10 FAIL.

Function
REQ-018 Latency SHALL be 1 cycle: voted_valid_o and all err_* outputs reflect valid_i/inputs of the previous cycle; err_* outputs are 0 whenever voted_valid_o is 0.
REQ-019 TMR, per channel: all three equal -> no error; exactly two equal -> output the agreeing value, corrected, the odd replica is culprit; all pairwise different -> bitwise majority output, uncorrectable, no culprit.
REQ-020 Per replica, a consecutive-culprit counter SHALL increment on each valid cycle where the replica is culprit in any channel, reset to 0 on a valid cycle where it is not, hold when valid_i=0.
REQ-021 TMR -> DUPLEX when a counter reaches PERM_THR: set that replica_faulty_o bit, exclude the replica; with multiple simultaneous, exclude the lowest index only.
REQ-022 DUPLEX: compare the two healthy replicas per channel; equal -> output that value; unequal -> output the lower-index healthy replica, err_uncorr_o=1.
REQ-023 DUPLEX -> FAIL after PERM_THR consecutive valid mismatching cycles (single shared counter, reset on a valid matching cycle).
REQ-024 FAIL: output lower-index healthy replica, err_uncorr_o=1 on every valid cycle; leaves FAIL only by clear_i or reset.
REQ-025 err_cnt_o SHALL saturate at 2^CNT_W-1, never wrap.
REQ-026 clear_i SHALL zero err_cnt_o, all culprit/mismatch counters and replica_faulty_o, and force mode TMR next cycle; clear_i has priority over a same-cycle event, which is not counted, but voted data and err_* for that cycle are still produced.
REQ-027 voted_o SHALL hold its last value when valid_i=0.

Reset
REQ-028 On rst_n low, asynchronously: voted_o=0, voted_valid_o=0, all err_* =0, err_cnt_o=0, replica_faulty_o=0, mode_o=TMR, all internal counters 0.
REQ-029 Reset asserted mid-operation SHALL abort any pending transition; first cycle after release behaves as TMR with empty history.

Configuration
REQ-030 Macro CV32E40P_FT_REPLICA_EXCLUDE_EN defined: REQ-020..REQ-024 implemented as above.
REQ-031 Macro undefined: no exclusion logic; mode_o tied 00, replica_faulty_o tied 0, voting always per REQ-019; err_cnt_o and all err_* still operate.

Verification (N_CH=2, CH_W=8, PERM_THR=4, CNT_W=4, macro defined unless stated)
REQ-032 All inputs 0xA53C, valid_i=1 -> next cycle voted_o=0xA53C, voted_valid_o=1, all err_* =0.
REQ-033 in_2_i=0x00FF, in_1_i=in_3_i=0x0000 -> voted_o=0x0000, err_corrected_o=1, err_detected_o=1, err_cnt_o=1.
REQ-034 Channel1 inputs 0x01/0x02/0x04, channel0 all 0x10 -> voted_o=0x0010, err_uncorr_o=1, err_corrected_o=0, err_cnt_o unchanged.
REQ-035 in_3_i culprit 4 consecutive valid cycles (one idle cycle between 2nd and 3rd) -> replica_faulty_o=3'b100, mode_o=01 after 4th; repeat with macro undefined -> mode_o stays 00.
REQ-036 In DUPLEX, assert clear_i together with a mismatch -> next cycle mode_o=00, replica_faulty_o=0, err_cnt_o=0, err_uncorr_o=1 for that cycle.
REQ-037 20 consecutive corrected cycles -> err_cnt_o=15; rst_n pulsed low mid-sequence -> all outputs 0 immediately.
